// File: rtl/term_config_chain_writer.sv
// term_config_chain_writer: loads parallel words and shifts them LSB-first into a tile config chain, pads to even, then latches
module term_config_chain_writer #(
  parameter int NoConfigBits = 32,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ConfigDataOut,
  output logic                  ConfigShiftEn,
  output logic                  ConfigLatch,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           bits_sent
);
  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam logic [15:0]   LAST  = 16'(NoConfigBits);
  localparam logic [CW-1:0] WLAST = CW'(WORD_WIDTH);
  localparam bit ODD  = (NoConfigBits % 2) == 1;
  localparam bit NONE = NoConfigBits == 0;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PAD, LATCH, FIN} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] bits_q, bits_d;
  logic rdy_q, rdy_d, sdo_q, sdo_d, sen_q, sen_d, lat_q, lat_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    case (state_q)
      IDLE: if (start) begin
        bits_d  = '0;
        state_d = NONE ? FIN : LOAD;
      end
      LOAD: if (word_valid) begin
        shreg_d = word_data;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        bits_d  = bits_q + 1'b1;
        state_d = (bits_d == LAST) ? (ODD ? PAD : LATCH) : (cnt_d == WLAST) ? LOAD : SHIFT;
      end
      PAD: begin
        bits_d  = bits_q + 1'b1;
        state_d = LATCH;
      end
      LATCH:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with state_q
    rdy_d  = state_d == LOAD;
    sen_d  = state_d == SHIFT || state_d == PAD;
    sdo_d  = state_d == SHIFT && shreg_d[0];
    lat_d  = state_d == LATCH;
    busy_d = state_d == LOAD || state_d == SHIFT || state_d == PAD || state_d == LATCH;
    done_d = state_d == FIN;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      rdy_q   <= 1'b0;
      sdo_q   <= 1'b0;
      sen_q   <= 1'b0;
      lat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      rdy_q   <= rdy_d;
      sdo_q   <= sdo_d;
      sen_q   <= sen_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign word_ready    = rdy_q;
  assign ConfigDataOut = sdo_q;
  assign ConfigShiftEn = sen_q;
  assign ConfigLatch   = lat_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bits_sent     = bits_q;
endmodule

// File: tb/tb_term_config_chain_writer.sv
// tb_term_config_chain_writer: directed tests over four writer configurations (32, 5, 40 and 0 chain bits)
module tb_term_config_chain_writer;
  logic CLK = 1'b0, reset = 1'b1, word_valid = 1'b0, mon_clr = 1'b0;
  logic [3:0] start = '0;
  logic [31:0] word_data = '0;
  logic [3:0] rdy, sdo, sen, lat, bsy, dn;
  logic [15:0] bs [4];
  int checks = 0, fails = 0, sel = 0;
  int cyc, nsh, nlat, lat_cyc, ndone, done_cyc, bad, nacc, nrdy, nbusy, first_sh, last_sh;
  logic [63:0] shbits;

  always #5 CLK = ~CLK;

  term_config_chain_writer #(.NoConfigBits(32), .WORD_WIDTH(32)) u0 (.CLK(CLK), .reset(reset), .start(start[0]),
    .word_data(word_data), .word_valid(word_valid), .word_ready(rdy[0]), .ConfigDataOut(sdo[0]),
    .ConfigShiftEn(sen[0]), .ConfigLatch(lat[0]), .busy(bsy[0]), .done(dn[0]), .bits_sent(bs[0]));
  term_config_chain_writer #(.NoConfigBits(5), .WORD_WIDTH(32)) u1 (.CLK(CLK), .reset(reset), .start(start[1]),
    .word_data(word_data), .word_valid(word_valid), .word_ready(rdy[1]), .ConfigDataOut(sdo[1]),
    .ConfigShiftEn(sen[1]), .ConfigLatch(lat[1]), .busy(bsy[1]), .done(dn[1]), .bits_sent(bs[1]));
  term_config_chain_writer #(.NoConfigBits(40), .WORD_WIDTH(32)) u2 (.CLK(CLK), .reset(reset), .start(start[2]),
    .word_data(word_data), .word_valid(word_valid), .word_ready(rdy[2]), .ConfigDataOut(sdo[2]),
    .ConfigShiftEn(sen[2]), .ConfigLatch(lat[2]), .busy(bsy[2]), .done(dn[2]), .bits_sent(bs[2]));
  term_config_chain_writer #(.NoConfigBits(0), .WORD_WIDTH(32)) u3 (.CLK(CLK), .reset(reset), .start(start[3]),
    .word_data(word_data), .word_valid(word_valid), .word_ready(rdy[3]), .ConfigDataOut(sdo[3]),
    .ConfigShiftEn(sen[3]), .ConfigLatch(lat[3]), .busy(bsy[3]), .done(dn[3]), .bits_sent(bs[3]));

  // observes the selected instance once per cycle, mid-cycle
  always @(negedge CLK) begin
    if (mon_clr) begin
      cyc = 0; nsh = 0; shbits = '0; nlat = 0; lat_cyc = -1; ndone = 0; done_cyc = -1;
      bad = 0; nacc = 0; nrdy = 0; nbusy = 0; first_sh = -1; last_sh = -1;
    end else begin
      cyc++;
      if (sen[sel]) begin
        if (nsh < 64) shbits[nsh] = sdo[sel];
        if (nsh == 0) first_sh = cyc;
        last_sh = cyc;
        nsh++;
      end else if (sdo[sel]) bad++;
      if (lat[sel]) begin nlat++; lat_cyc = cyc; end
      if (dn[sel]) begin ndone++; done_cyc = cyc; end
      if (rdy[sel]) nrdy++;
      if (rdy[sel] && word_valid) nacc++;
      if (bsy[sel]) nbusy++;
    end
  end

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic mon_reset;
    mon_clr = 1'b1;
    @(negedge CLK); #1;
    mon_clr = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int max, input string name);
    for (int k = 0; k < max && ndone == 0; k++) tick();
    checks++; if (ndone == 0) begin fails++; $display("FAIL %s_timeout: no done within %0d cycles", name, max); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rdy[i], sdo[i], sen[i], lat[i], bsy[i], dn[i]} !== 6'b0) begin
        fails++; $display("FAIL reset_outs[%0d]: got %b expected 000000", i, {rdy[i], sdo[i], sen[i], lat[i], bsy[i], dn[i]}); end
      checks++; if (bs[i] !== 16'd0) begin fails++; $display("FAIL reset_bits[%0d]: got %0d expected 0", i, bs[i]); end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_word;
    sel = 0; mon_reset();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    checks++; if ({bsy[0], rdy[0]} !== 2'b11) begin fails++; $display("FAIL t1_load: busy,ready got %b expected 11", {bsy[0], rdy[0]}); end
    word_data = 32'h0000_0001; word_valid = 1'b1; tick(); word_valid = 1'b0;
    wait_done(60, "t1");
    checks++; if (nsh !== 32) begin fails++; $display("FAIL t1_nshift: got %0d expected 32", nsh); end
    checks++; if (shbits !== 64'h1) begin fails++; $display("FAIL t1_bits: got %h expected %h", shbits, 64'h1); end
    checks++; if (first_sh !== 3 || last_sh !== 34) begin fails++; $display("FAIL t1_window: got %0d..%0d expected 3..34", first_sh, last_sh); end
    checks++; if (nlat !== 1 || lat_cyc !== 35) begin fails++; $display("FAIL t1_latch: got n=%0d at %0d expected n=1 at 35", nlat, lat_cyc); end
    checks++; if (done_cyc !== 36) begin fails++; $display("FAIL t1_done: got cycle %0d expected 36", done_cyc); end
    checks++; if (bs[0] !== 16'd32) begin fails++; $display("FAIL t1_bits_sent: got %0d expected 32", bs[0]); end
    checks++; if (bad !== 0 || nacc !== 1) begin fails++; $display("FAIL t1_misc: data_when_idle=%0d accepts=%0d expected 0,1", bad, nacc); end
  endtask

  task automatic test_odd_pad;
    sel = 1; mon_reset();
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    word_data = 32'hFFFF_FFFF; word_valid = 1'b1; tick(); word_valid = 1'b0;
    wait_done(30, "t2");
    checks++; if (nsh !== 6) begin fails++; $display("FAIL t2_nshift: got %0d expected 6", nsh); end
    checks++; if (shbits !== 64'h1F) begin fails++; $display("FAIL t2_bits: got %h expected %h", shbits, 64'h1F); end
    checks++; if (first_sh !== 3 || last_sh !== 8) begin fails++; $display("FAIL t2_window: got %0d..%0d expected 3..8", first_sh, last_sh); end
    checks++; if (nlat !== 1 || lat_cyc !== 9 || done_cyc !== 10) begin
      fails++; $display("FAIL t2_latch_done: got n=%0d latch %0d done %0d expected 1,9,10", nlat, lat_cyc, done_cyc); end
    checks++; if (bs[1] !== 16'd6) begin fails++; $display("FAIL t2_bits_sent: got %0d expected 6", bs[1]); end
  endtask

  task automatic test_multi_word;
    sel = 2; mon_reset();
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    word_data = 32'hA5A5_A5A5; word_valid = 1'b1; tick(); word_valid = 1'b0;
    for (int k = 0; k < 40 && rdy[2] !== 1'b1; k++) tick();
    checks++; if (rdy[2] !== 1'b1) begin fails++; $display("FAIL t3_reload: ready got %b expected 1", rdy[2]); end
    repeat (3) tick();
    word_data = 32'h0000_00C3; word_valid = 1'b1; tick(); word_valid = 1'b0;
    wait_done(30, "t3");
    checks++; if (nsh !== 40) begin fails++; $display("FAIL t3_nshift: got %0d expected 40", nsh); end
    checks++; if (shbits !== 64'h0000_00C3_A5A5_A5A5) begin fails++; $display("FAIL t3_bits: got %h expected %h", shbits, 64'h0000_00C3_A5A5_A5A5); end
    checks++; if (last_sh - first_sh + 1 - nsh !== 4) begin fails++; $display("FAIL t3_gap: got %0d idle cycles expected 4", last_sh - first_sh + 1 - nsh); end
    checks++; if (nacc !== 2 || bad !== 0) begin fails++; $display("FAIL t3_misc: accepts=%0d data_when_idle=%0d expected 2,0", nacc, bad); end
    checks++; if (nlat !== 1 || done_cyc !== lat_cyc + 1) begin fails++; $display("FAIL t3_latch: got n=%0d latch %0d done %0d", nlat, lat_cyc, done_cyc); end
    checks++; if (bs[2] !== 16'd40) begin fails++; $display("FAIL t3_bits_sent: got %0d expected 40", bs[2]); end
  endtask

  task automatic test_zero_bits;
    sel = 3; mon_reset();
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    wait_done(10, "t4");
    repeat (3) tick();
    checks++; if (ndone !== 1 || done_cyc !== 2) begin fails++; $display("FAIL t4_done: got n=%0d at %0d expected n=1 at 2", ndone, done_cyc); end
    checks++; if (nrdy !== 0 || nsh !== 0 || nlat !== 0 || nbusy !== 0) begin
      fails++; $display("FAIL t4_quiet: ready=%0d shifts=%0d latch=%0d busy=%0d expected all 0", nrdy, nsh, nlat, nbusy); end
    checks++; if (bs[3] !== 16'd0) begin fails++; $display("FAIL t4_bits_sent: got %0d expected 0", bs[3]); end
  endtask

  task automatic test_reset_mid_write;
    sel = 0; mon_reset();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    word_data = 32'hFFFF_FFFF; word_valid = 1'b1; tick(); word_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1; tick();
    checks++; if (nsh !== 10) begin fails++; $display("FAIL t5_pre_shifts: got %0d expected 10", nsh); end
    checks++; if ({rdy[0], sdo[0], sen[0], lat[0], bsy[0], dn[0]} !== 6'b0 || bs[0] !== 16'd0) begin
      fails++; $display("FAIL t5_reset_outs: got %b bits=%0d expected 000000 bits=0", {rdy[0], sdo[0], sen[0], lat[0], bsy[0], dn[0]}, bs[0]); end
    reset = 1'b0;
    repeat (5) tick();
    checks++; if (nlat !== 0 || ndone !== 0) begin fails++; $display("FAIL t5_no_latch: latch=%0d done=%0d expected 0,0", nlat, ndone); end
    mon_reset();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    word_data = 32'h1234_5678; word_valid = 1'b1; tick(); word_valid = 1'b0;
    wait_done(60, "t5");
    checks++; if (nsh !== 32 || shbits !== 64'h1234_5678) begin fails++; $display("FAIL t5_rewrite: got n=%0d bits=%h expected 32,%h", nsh, shbits, 64'h1234_5678); end
    checks++; if (nlat !== 1 || bs[0] !== 16'd32) begin fails++; $display("FAIL t5_rewrite_end: latch=%0d bits_sent=%0d expected 1,32", nlat, bs[0]); end
  endtask

  task automatic test_back_to_back;
    sel = 2; mon_reset();
    word_data = 32'h0000_00FF; word_valid = 1'b1;
    repeat (3) tick();
    checks++; if (nrdy !== 0 || nacc !== 0) begin fails++; $display("FAIL t6_idle_valid: ready=%0d accepts=%0d expected 0,0", nrdy, nacc); end
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    tick();
    repeat (5) tick();
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    wait_done(60, "t6");
    repeat (5) tick();
    word_valid = 1'b0;
    checks++; if (ndone !== 1 || nlat !== 1) begin fails++; $display("FAIL t6_single: done=%0d latch=%0d expected 1,1", ndone, nlat); end
    checks++; if (nacc !== 2 || nrdy !== 2) begin fails++; $display("FAIL t6_words: accepts=%0d ready=%0d expected 2,2", nacc, nrdy); end
    checks++; if (nsh !== 40 || shbits !== 64'h0000_00FF_0000_00FF) begin
      fails++; $display("FAIL t6_bits: got n=%0d bits=%h expected 40,%h", nsh, shbits, 64'h0000_00FF_0000_00FF); end
    checks++; if (last_sh - first_sh + 1 - nsh !== 1) begin fails++; $display("FAIL t6_gap: got %0d idle cycles expected 1", last_sh - first_sh + 1 - nsh); end
    checks++; if (bs[2] !== 16'd40 || bsy[2] !== 1'b0) begin fails++; $display("FAIL t6_hold: bits_sent=%0d busy=%b expected 40,0", bs[2], bsy[2]); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_odd_pad();
    test_multi_word();
    test_zero_bits();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
